// File: rtl/vfifo_sync_fwft_ctrl.sv
// First-word-fall-through synchronous FIFO controller driving an external
// dual-port RAM whose read address is registered inside the RAM.
//
// Ports:
//   clk, rst              sole clock (rising edge), synchronous active-high reset
//   wr_en, wr_data        push request and word
//   full, almost_full     count == DEPTH, count >= AF_LEVEL (registered)
//   rd_en, rd_data        pop request, head word (valid while !empty)
//   empty, almost_empty   count == 0, count <= AE_LEVEL (registered)
//   count                 words stored
//   overflow, underflow   sticky rejected-push / rejected-pop flags
//   ram_d_a, ram_adr_a,
//   ram_we_a              RAM write port (combinational)
//   ram_adr_b             RAM read address, registered inside the RAM
//   ram_q_b               RAM read data from its registered address
module vfifo_sync_fwft_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic [DATA_WIDTH-1:0] ram_d_a,
   output logic [ADDR_WIDTH-1:0] ram_adr_a,
   output logic                  ram_we_a,
   output logic [ADDR_WIDTH-1:0] ram_adr_b,
   input  logic [DATA_WIDTH-1:0] ram_q_b
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [CW-1:0] wptr;
   logic [CW-1:0] rptr;
   logic [CW-1:0] wptr_nxt;
   logic [CW-1:0] rptr_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          push_ok;
   logic          pop_ok;

   // A push while full is legal only when the same cycle vacates a slot.
   always_comb begin
      pop_ok   = rd_en && !empty && !rst;
      push_ok  = wr_en && (!full || pop_ok) && !rst;
      wptr_nxt = wptr + CW'(push_ok);
      rptr_nxt = rptr + CW'(pop_ok);
      cnt_nxt  = count + CW'(push_ok) - CW'(pop_ok);
   end

   assign ram_we_a  = push_ok;
   assign ram_adr_a = wptr[ADDR_WIDTH-1:0];
   assign ram_d_a   = wr_data;

   // Present the post-edge read pointer so the RAM's registered address
   // already points at the new head after a pop: no bubble between pops.
   assign ram_adr_b = rst ? '0 : rptr_nxt[ADDR_WIDTH-1:0];
   assign rd_data   = ram_q_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_C == '0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wptr         <= wptr_nxt;
         rptr         <= rptr_nxt;
         count        <= cnt_nxt;
         full         <= (cnt_nxt == DEPTH_C);
         empty        <= (cnt_nxt == '0);
         almost_full  <= (cnt_nxt >= AF_C);
         almost_empty <= (cnt_nxt <= AE_C);
         if (wr_en && !push_ok)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vfifo_sync_fwft_ctrl.sv
// Testbench for vfifo_sync_fwft_ctrl: directed scenarios plus random
// traffic against a queue-based reference model and a behavioural RAM.
module tb_vfifo_sync_fwft_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          almost_full;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          empty;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic [DW-1:0] ram_d_a;
   logic [AW-1:0] ram_adr_a;
   logic          ram_we_a;
   logic [AW-1:0] ram_adr_b;
   logic [DW-1:0] ram_q_b;

   vfifo_sync_fwft_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AF_LEVEL  (3),
      .AE_LEVEL  (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .almost_full (almost_full),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .ram_d_a     (ram_d_a),
      .ram_adr_a   (ram_adr_a),
      .ram_we_a    (ram_we_a),
      .ram_adr_b   (ram_adr_b),
      .ram_q_b     (ram_q_b)
   );

   always #5 clk = ~clk;

   // Dual-port RAM with registered read address, both ports on clk.
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] adr_b_q;
   always @(posedge clk) begin
      if (ram_we_a)
         mem[ram_adr_a] <= ram_d_a;
      adr_b_q <= ram_adr_b;
   end
   assign ram_q_b = mem[adr_b_q];

   int n_chk = 0;
   int n_err = 0;

   // Reference model: contents as a queue, totals of accepted ops.
   logic [DW-1:0] q[$];
   int  wr_total = 0;
   int  rd_total = 0;
   bit  m_ovf = 0;
   bit  m_udf = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic chk_state();
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= 3));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      if (q.size() > 0)
         chk("rd_data", 32'(rd_data), 32'(q[0]));
   endtask

   // One clock cycle: drive at negedge, check combinational RAM port,
   // advance the model at the edge, then check registered state.
   task automatic step(input bit w, input logic [DW-1:0] d,
                       input bit r, input bit x);
      bit pop;
      bit push;
      @(negedge clk);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      rst     = x;
      #1;
      pop  = !x && r && q.size() > 0;
      push = !x && w && (q.size() < DEPTH || pop);
      chk("ram_we_a", 32'(ram_we_a), 32'(push));
      chk("ram_adr_b", 32'(ram_adr_b),
          x ? 32'd0 : 32'((rd_total + int'(pop)) % DEPTH));
      if (push) begin
         chk("ram_adr_a", 32'(ram_adr_a), 32'(wr_total % DEPTH));
         chk("ram_d_a", 32'(ram_d_a), 32'(d));
      end
      @(posedge clk);
      if (x) begin
         q.delete();
         wr_total = 0;
         rd_total = 0;
         m_ovf    = 0;
         m_udf    = 0;
      end else begin
         if (w && !push)
            m_ovf = 1;
         if (r && q.size() == 0)
            m_udf = 1;
         if (pop) begin
            void'(q.pop_front());
            rd_total++;
         end
         if (push) begin
            q.push_back(d);
            wr_total++;
         end
      end
      #1;
      chk_state();
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 1);

      // Single push into empty appears next cycle.
      step(1, 8'hA1, 0, 0);
      chk("a1_data", 32'(rd_data), 32'h0A1);
      chk("a1_empty", 32'(empty), 32'd0);
      chk("a1_count", 32'(count), 32'd1);
      chk("a1_ae", 32'(almost_empty), 32'd1);
      step(0, 8'h00, 1, 0);

      // Fill to full, overflow, drain in order.
      for (int i = 0; i < 4; i++) begin
         step(1, 8'(8'h10 + i), 0, 0);
         if (i == 2)
            chk("af_at3", 32'(almost_full), 32'd1);
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd4);
      step(1, 8'h14, 0, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", 32'(rd_data), 32'(8'h10 + i));
         step(0, 8'h00, 1, 0);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Push and pop together while full.
      for (int i = 0; i < 4; i++)
         step(1, 8'(8'h20 + i), 0, 0);
      chk("fp_head", 32'(rd_data), 32'h20);
      step(1, 8'h55, 1, 0);
      chk("fp_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i == 3)
            chk("fp_55", 32'(rd_data), 32'h55);
         step(0, 8'h00, 1, 0);
      end

      // Streaming push+pop across pointer wrap.
      step(1, 8'hFF, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, 8'(i), 1, 0);
         chk("stream_count", 32'(count), 32'd1);
      end
      chk("stream_last", 32'(rd_data), 32'd19);
      step(0, 8'h00, 1, 0);

      // Pop on empty, then push still reads back.
      step(0, 8'h00, 1, 0);
      chk("udf_set", 32'(underflow), 32'd1);
      chk("udf_count", 32'(count), 32'd0);
      step(1, 8'h77, 0, 0);
      chk("after_udf", 32'(rd_data), 32'h77);
      step(0, 8'h00, 1, 0);

      // Push into empty with rd_en: push accepted, pop flagged.
      step(1, 8'h3C, 1, 0);
      chk("pe_count", 32'(count), 32'd1);
      chk("pe_data", 32'(rd_data), 32'h3C);

      // Reset mid-operation with wr_en high.
      step(1, 8'h41, 0, 0);
      step(1, 8'h42, 0, 0);
      step(1, 8'h99, 0, 1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom),
              $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/vfifo_sync_fwft_ctrl.md
VFIFO_SYNC_FWFT_CTRL -- requirements
Module: vfifo_sync_fwft_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- DATA_WIDTH, 8, word width.
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2^ADDR_WIDTH.
- AF_LEVEL, DEPTH-1, almost_full threshold.
- AE_LEVEL, 1, almost_empty threshold.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are listed as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_en, in, 1, push request.
- wr_data, in, DATA_WIDTH, push word.
- full, out, 1, count == DEPTH.
- almost_full, out, 1, count >= AF_LEVEL.
- rd_en, in, 1, pop request.
- rd_data, out, DATA_WIDTH, head word (first-word-fall-through).
- empty, out, 1, count == 0.
- almost_empty, out, 1, count <= AE_LEVEL.
- count, out, ADDR_WIDTH+1, words stored.
- overflow, out, 1, sticky: push rejected.
- underflow, out, 1, sticky: pop rejected.
- ram_d_a, out, DATA_WIDTH, RAM write data.
- ram_adr_a, out, ADDR_WIDTH, RAM write address.
- ram_we_a, out, 1, RAM write enable.
- ram_adr_b, out, ADDR_WIDTH, RAM read address, registered inside the RAM.
- ram_q_b, in, DATA_WIDTH, RAM read data, combinational from the RAM's registered read address.
REQ-003 The block SHALL drive a dual-port RAM with a registered read address, with RAM clk_a and clk_b both tied to clk.

Function
REQ-004 push_ok SHALL be wr_en && (!full || pop_ok); pop_ok SHALL be rd_en && !empty.
REQ-005 Write and read pointers SHALL be ADDR_WIDTH+1 bits, incrementing modulo 2^(ADDR_WIDTH+1); RAM addresses SHALL be the low ADDR_WIDTH bits, so addresses wrap from DEPTH-1 to 0.
REQ-006 RAM write outputs SHALL be combinational:
- ram_we_a = push_ok.
- ram_adr_a = wptr[ADDR_WIDTH-1:0].
- ram_d_a = wr_data.
REQ-007 Read-address lookahead: ram_adr_b SHALL be (rptr + pop_ok)[ADDR_WIDTH-1:0], and 0 while rst is high. The RAM's internal read address therefore always equals rptr after each edge.
REQ-008 rd_data SHALL equal ram_q_b (no extra register); rd_data is valid whenever empty == 0.
REQ-009 Latencies:
- A word pushed into an empty FIFO at edge k SHALL appear on rd_data, with empty == 0, in the cycle after edge k.
- A pop at edge k SHALL present the next word in the cycle after edge k, giving full throughput of one pop per cycle.
REQ-010 count SHALL update at each edge as count + push_ok - pop_ok; simultaneous push_ok and pop_ok leave count unchanged.
REQ-011 full, empty, almost_full and almost_empty SHALL be registered, updated at the same edge as count from the next count value, with no combinational path from wr_en or rd_en.
REQ-012 Push while full with a simultaneous pop SHALL be accepted: it writes the slot being vacated, rd_data shows the old head during that cycle, and count stays DEPTH.
REQ-013 Push while full without a pop SHALL be dropped (ram_we_a = 0) and SHALL set overflow at the next edge.
REQ-014 rd_en while empty SHALL be ignored, with pointers unchanged, and SHALL set underflow at the next edge.
REQ-015 A push into an empty FIFO with rd_en in the same cycle SHALL be accepted; the pop is rejected and flagged as underflow.
REQ-016 overflow and underflow SHALL remain set until rst.

Reset
REQ-017 While rst is high at an edge, the block SHALL set:
- wptr = rptr = count = 0;
- empty = 1, almost_empty = 1, full = 0, overflow = 0, underflow = 0;
- almost_full = (AF_LEVEL == 0).
REQ-018 rst SHALL override pending push and pop: ram_we_a = 0 and ram_adr_b = 0 while rst is high, and stored contents are discarded logically.
REQ-019 Reset asserted mid-operation SHALL give empty == 1 in the cycle after the reset edge, regardless of prior state.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then push 0xA1 for one cycle -> next cycle: empty=0, rd_data=0xA1, count=1, almost_empty=1.
- Push 0x10, 0x11, 0x12, 0x13 back-to-back -> full=1, count=4, almost_full=1 after the third push. A further push of 0x14 alone -> dropped, overflow=1; then pops return 0x10..0x13 in order, one per cycle.
- Full FIFO, push 0x55 and pop in the same cycle -> count stays 4; the pop returns the old head; 0x55 is returned as the 4th subsequent word.
- 20 cycles of simultaneous push (incrementing 0x00..) and pop starting with 1 word stored -> count constant at 1, data in order across pointer wrap.
- Pop on empty -> underflow=1, count=0, pointers unchanged; the next push still reads back correctly.
- Fill to 3, assert rst for one cycle together with wr_en -> count=0, empty=1, overflow=0, underflow=0; no RAM write during reset.
